// File: rtl/mor1kx_branch_resolver.sv
// rtl/mor1kx_branch_resolver.sv - resolves predicted conditional branches, trains the predictor, redirects fetch on mispredict
// Optional MOR1KX_BRANCH_RESOLVER_STATS_EN adds branch/mispredict counters.
module mor1kx_branch_resolver #(
  parameter OPTION_OPERAND_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            predict_valid_i,
  input  logic                            predict_flag_i,
  input  logic                            predict_bf_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] predict_pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] predict_target_i,
  output logic                            predict_ready_o,
  input  logic                            resolve_valid_i,
  input  logic                            flag_i,
  input  logic                            pipeline_flush_i,
  output logic                            redirect_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
  input  logic                            redirect_ack_i,
  output logic                            update_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] update_pc_o,
  output logic                            update_taken_o,
  output logic                            update_mispredict_o
`ifdef MOR1KX_BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0]                     branch_count_o,
  output logic [31:0]                     mispredict_count_o
`endif
);

  localparam logic STATE_IDLE     = 1'b0;
  localparam logic STATE_REDIRECT = 1'b1;

  logic                            state;
  logic                            ent_flag   [2];
  logic                            ent_bf     [2];
  logic [OPTION_OPERAND_WIDTH-1:0] ent_pc     [2];
  logic [OPTION_OPERAND_WIDTH-1:0] ent_target [2];
  logic                            wr_ptr;
  logic                            rd_ptr;
  logic [1:0]                      count;

  logic                            idle;
  logic                            full;
  logic                            empty;
  logic                            pop;
  logic                            push;
  logic                            pop_taken;
  logic                            pop_mispredict;
  logic                            head_flag;
  logic                            head_bf;
  logic [OPTION_OPERAND_WIDTH-1:0] head_pc;
  logic [OPTION_OPERAND_WIDTH-1:0] head_target;

  assign idle  = (state == STATE_IDLE);
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  assign head_flag   = ent_flag[rd_ptr];
  assign head_bf     = ent_bf[rd_ptr];
  assign head_pc     = ent_pc[rd_ptr];
  assign head_target = ent_target[rd_ptr];

  // A full queue still takes a push when the oldest entry is resolved in the
  // same cycle; if that resolve mispredicts the push is dropped below.
  assign predict_ready_o = idle & (~full | resolve_valid_i);

  assign pop            = resolve_valid_i & ~empty & idle & ~pipeline_flush_i;
  assign pop_taken      = head_bf ? flag_i : ~flag_i;
  assign pop_mispredict = pop & (flag_i != head_flag);
  assign push           = predict_valid_i & predict_ready_o & ~pipeline_flush_i & ~pop_mispredict;

  always_ff @(posedge clk) begin
    if (push) begin
      ent_flag[wr_ptr]   <= predict_flag_i;
      ent_bf[wr_ptr]     <= predict_bf_i;
      ent_pc[wr_ptr]     <= predict_pc_i;
      ent_target[wr_ptr] <= predict_target_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (pipeline_flush_i | pop_mispredict) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= STATE_IDLE;
      redirect_pc_o <= '0;
    end else if (pipeline_flush_i) begin
      state <= STATE_IDLE;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (pop_mispredict) begin
            state         <= STATE_REDIRECT;
            // Not-taken resumes past the delay slot.
            redirect_pc_o <= pop_taken ? head_target
                                       : head_pc + OPTION_OPERAND_WIDTH'(8);
          end
        end
        default: begin
          if (redirect_ack_i)
            state <= STATE_IDLE;
        end
      endcase
    end
  end

  assign redirect_o = (state == STATE_REDIRECT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_valid_o      <= 1'b0;
      update_pc_o         <= '0;
      update_taken_o      <= 1'b0;
      update_mispredict_o <= 1'b0;
    end else begin
      update_valid_o <= pop;
      if (pop) begin
        update_pc_o         <= head_pc;
        update_taken_o      <= pop_taken;
        update_mispredict_o <= pop_mispredict;
      end
    end
  end

`ifdef MOR1KX_BRANCH_RESOLVER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count_o     <= 32'd0;
      mispredict_count_o <= 32'd0;
    end else begin
      if (pop)
        branch_count_o <= branch_count_o + 32'd1;
      if (pop_mispredict)
        mispredict_count_o <= mispredict_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mor1kx_branch_resolver.sv
// tb/tb_mor1kx_branch_resolver.sv - directed and random checks of mor1kx_branch_resolver against a queue model
module tb_mor1kx_branch_resolver;

  typedef struct {
    logic        flag;
    logic        bf;
    logic [31:0] pc;
    logic [31:0] target;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        predict_valid_i;
  logic        predict_flag_i;
  logic        predict_bf_i;
  logic [31:0] predict_pc_i;
  logic [31:0] predict_target_i;
  logic        predict_ready_o;
  logic        resolve_valid_i;
  logic        flag_i;
  logic        pipeline_flush_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ack_i;
  logic        update_valid_o;
  logic [31:0] update_pc_o;
  logic        update_taken_o;
  logic        update_mispredict_o;
`ifdef MOR1KX_BRANCH_RESOLVER_STATS_EN
  logic [31:0] branch_count_o;
  logic [31:0] mispredict_count_o;
`endif

  int errors = 0;
  int checks = 0;

  ent_t        q[$];
  logic        m_redir;
  logic [31:0] m_rpc;
  logic        m_uv;
  logic        m_ut;
  logic        m_um;
  logic [31:0] m_upc;
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  always #5 clk = ~clk;

  mor1kx_branch_resolver #(.OPTION_OPERAND_WIDTH(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .predict_valid_i     (predict_valid_i),
    .predict_flag_i      (predict_flag_i),
    .predict_bf_i        (predict_bf_i),
    .predict_pc_i        (predict_pc_i),
    .predict_target_i    (predict_target_i),
    .predict_ready_o     (predict_ready_o),
    .resolve_valid_i     (resolve_valid_i),
    .flag_i              (flag_i),
    .pipeline_flush_i    (pipeline_flush_i),
    .redirect_o          (redirect_o),
    .redirect_pc_o       (redirect_pc_o),
    .redirect_ack_i      (redirect_ack_i),
    .update_valid_o      (update_valid_o),
    .update_pc_o         (update_pc_o),
    .update_taken_o      (update_taken_o),
    .update_mispredict_o (update_mispredict_o)
`ifdef MOR1KX_BRANCH_RESOLVER_STATS_EN
    ,
    .branch_count_o      (branch_count_o),
    .mispredict_count_o  (mispredict_count_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_redir = 1'b0;
    m_rpc   = 32'd0;
    m_uv    = 1'b0;
    m_ut    = 1'b0;
    m_um    = 1'b0;
    m_upc   = 32'd0;
    m_bc    = 32'd0;
    m_mc    = 32'd0;
  endtask

  task automatic drive(input logic pv, input logic pf, input logic pb,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic rv, input logic fi, input logic fl, input logic ack);
    predict_valid_i  = pv;
    predict_flag_i   = pf;
    predict_bf_i     = pb;
    predict_pc_i     = pc;
    predict_target_i = tgt;
    resolve_valid_i  = rv;
    flag_i           = fi;
    pipeline_flush_i = fl;
    redirect_ack_i   = ack;
  endtask

  task automatic check_regs();
    chk("update_valid", 32'(update_valid_o), 32'(m_uv));
    if (m_uv) begin
      chk("update_taken", 32'(update_taken_o), 32'(m_ut));
      chk("update_mispredict", 32'(update_mispredict_o), 32'(m_um));
      chk("update_pc", update_pc_o, m_upc);
    end
    chk("redirect", 32'(redirect_o), 32'(m_redir));
    if (m_redir)
      chk("redirect_pc", redirect_pc_o, m_rpc);
`ifdef MOR1KX_BRANCH_RESOLVER_STATS_EN
    chk("branch_count", branch_count_o, m_bc);
    chk("mispredict_count", mispredict_count_o, m_mc);
`endif
  endtask

  // Entered one time unit after a rising edge with inputs already driven.
  task automatic step();
    logic exp_ready;
    logic do_push;
    logic mis;
    logic tk;
    ent_t e;
    ent_t n;
    #2;
    exp_ready = !m_redir && (q.size() < 2 || resolve_valid_i);
    chk("predict_ready", 32'(predict_ready_o), 32'(exp_ready));
    chk("redirect_pre", 32'(redirect_o), 32'(m_redir));
    @(posedge clk);
    m_uv = 1'b0;
    if (pipeline_flush_i) begin
      q.delete();
      m_redir = 1'b0;
    end else if (m_redir) begin
      if (redirect_ack_i)
        m_redir = 1'b0;
    end else begin
      do_push = predict_valid_i && exp_ready;
      mis = 1'b0;
      if (resolve_valid_i && q.size() > 0) begin
        e = q.pop_front();
        tk  = e.bf ? flag_i : !flag_i;
        mis = (flag_i != e.flag);
        m_uv = 1'b1;
        m_ut = tk;
        m_um = mis;
        m_upc = e.pc;
        m_bc = m_bc + 32'd1;
        if (mis) begin
          m_mc = m_mc + 32'd1;
          q.delete();
          m_redir = 1'b1;
          m_rpc = tk ? e.target : e.pc + 32'd8;
        end
      end
      if (do_push && !mis) begin
        n.flag = predict_flag_i;
        n.bf = predict_bf_i;
        n.pc = predict_pc_i;
        n.target = predict_target_i;
        q.push_back(n);
      end
    end
    #1;
    check_regs();
  endtask

  task automatic idle_step();
    drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_redirect", 32'(redirect_o), 32'd0);
    chk("rst_update_valid", 32'(update_valid_o), 32'd0);
    chk("rst_update_taken", 32'(update_taken_o), 32'd0);
    chk("rst_update_mispredict", 32'(update_mispredict_o), 32'd0);
    chk("rst_redirect_pc", redirect_pc_o, 32'd0);
    chk("rst_update_pc", update_pc_o, 32'd0);
    chk("rst_predict_ready", 32'(predict_ready_o), 32'd1);
    rst = 1'b0;

    // correct taken prediction
    drive(1, 1, 1, 32'h100, 32'h200, 0, 0, 0, 0); step();
    drive(0, 0, 0, 32'd0, 32'd0, 1, 1, 0, 0); step();
    chk("r019_taken", 32'(update_taken_o), 32'd1);
    chk("r019_mispredict", 32'(update_mispredict_o), 32'd0);
    idle_step();

    // mispredict to taken target, held until ack
    drive(1, 0, 1, 32'h100, 32'h200, 0, 0, 0, 0); step();
    drive(0, 0, 0, 32'd0, 32'd0, 1, 1, 0, 0); step();
    chk("r020_redirect_pc", redirect_pc_o, 32'h200);
    drive(1, 1, 1, 32'h300, 32'h400, 1, 1, 0, 0); step();
    drive(1, 1, 1, 32'h300, 32'h400, 0, 0, 0, 0); step();
    drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 1); step();
    idle_step();

    // mispredict to not-taken path wraps the fall-through address
    drive(1, 1, 1, 32'hFFFFFFFC, 32'h40, 0, 0, 0, 0); step();
    drive(0, 0, 0, 32'd0, 32'd0, 1, 0, 0, 0); step();
    chk("r021_redirect_pc", redirect_pc_o, 32'h4);
    drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 1); step();

    // full queue, then pop+push at full
    drive(1, 1, 1, 32'h500, 32'h600, 0, 0, 0, 0); step();
    drive(1, 0, 0, 32'h510, 32'h610, 0, 0, 0, 0); step();
    drive(1, 1, 0, 32'h520, 32'h620, 0, 0, 0, 0); step();
    drive(1, 0, 1, 32'h530, 32'h630, 1, 1, 0, 0); step();
    drive(0, 0, 0, 32'd0, 32'd0, 1, 0, 0, 0); step();
    drive(0, 0, 0, 32'd0, 32'd0, 1, 0, 0, 0); step();
    drive(0, 0, 0, 32'd0, 32'd0, 1, 0, 0, 0); step();

    // oldest mispredicts, younger entry discarded
    drive(1, 1, 1, 32'h700, 32'h800, 0, 0, 0, 0); step();
    drive(1, 1, 1, 32'h710, 32'h810, 0, 0, 0, 0); step();
    drive(0, 0, 0, 32'd0, 32'd0, 1, 0, 0, 0); step();
    drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 32'd0, 32'd0, 1, 1, 0, 0); step();
    chk("r023_no_update", 32'(update_valid_o), 32'd0);

    // flush during redirect
    drive(1, 0, 0, 32'h900, 32'hA00, 0, 0, 0, 0); step();
    drive(0, 0, 0, 32'd0, 32'd0, 1, 1, 0, 0); step();
    drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 1, 0); step();
    chk("r024_redirect_off", 32'(redirect_o), 32'd0);
    idle_step();

    // asynchronous reset mid-redirect
    drive(1, 1, 0, 32'hB00, 32'hC00, 0, 0, 0, 0); step();
    drive(0, 0, 0, 32'd0, 32'd0, 1, 0, 0, 0); step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_redirect", 32'(redirect_o), 32'd0);
    chk("async_rst_ready", 32'(predict_ready_o), 32'd1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    idle_step();
    idle_step();

    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hC))
                                       : ($urandom & 32'hFFFFFFFC);
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            pc, $urandom & 32'hFFFFFFFC,
            ($urandom_range(0, 9) < 4), $urandom_range(0, 1),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 3));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
